// File: rtl/uart_cmd_decoder_pkg.sv
// uart_cmd_decoder_pkg: host command codes, mode encodings, FSM/command enums and decode helper.
// Rev 1.0
`default_nettype none

package uart_cmd_decoder_pkg;

    localparam logic [7:0] CMD_DATA   = 8'h01;
    localparam logic [7:0] CMD_CTRL   = 8'h02;
    localparam logic [7:0] CMD_FREQ   = 8'h03;
    localparam logic [7:0] CMD_PERIOD = 8'h04;
    localparam logic [7:0] CMD_REPEAT = 8'h05;
    localparam logic [7:0] CMD_GLOBAL = 8'h06;

    localparam logic [1:0] ONE_SHOT = 2'b00;
    localparam logic [1:0] CONTINUE = 2'b01;
    localparam logic [1:0] REPEAT   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH,
        ST_AMT,
        ST_PAY,
        ST_ARG
    } state_t;

    typedef enum logic [2:0] {
        CM_NONE,
        CM_DATA,
        CM_CTRL,
        CM_FREQ,
        CM_PERIOD,
        CM_REPEAT,
        CM_GLOBAL
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        case (b)
            CMD_DATA:   decode_cmd = CM_DATA;
            CMD_CTRL:   decode_cmd = CM_CTRL;
            CMD_FREQ:   decode_cmd = CM_FREQ;
            CMD_PERIOD: decode_cmd = CM_PERIOD;
            CMD_REPEAT: decode_cmd = CM_REPEAT;
            CMD_GLOBAL: decode_cmd = CM_GLOBAL;
            default:    decode_cmd = CM_NONE;
        endcase
    endfunction

    function automatic logic has_channel(input cmd_t c);
        has_channel = (c == CM_DATA) || (c == CM_CTRL) || (c == CM_REPEAT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: reassembles UART bytes into host command frames and emits commit strobes.
// Rev 1.0
`default_nettype none

module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int OUTPUT_NUM     = 16,
    parameter int DATA_BIT       = 32,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int CH_W          = $clog2(OUTPUT_NUM)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [7:0]          data_i,
    input  logic                rx_done_tick_i,
    output logic                data_we_o,
    output logic                ctrl_we_o,
    output logic                freq_we_o,
    output logic                period_we_o,
    output logic                repeat_we_o,
    output logic                global_we_o,
    output logic [CH_W-1:0]     channel_o,
    output logic [7:0]          amount_o,
    output logic [DATA_BIT-1:0] pattern_o,
    output logic                idle_o,
    output logic [1:0]          mode_o,
    output logic                en_o,
    output logic [7:0]          slow_period_o,
    output logic [7:0]          fast_period_o,
    output logic [7:0]          repeat_o,
    output logic                stop_o,
    output logic                err_o
);

    localparam int PAY_BYTES = DATA_BIT / 8;
    localparam int IDX_W     = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state, state_d;
    cmd_t                cmd, cmd_in;
    logic [CH_W-1:0]     ch;
    logic                ch_ok;
    logic [7:0]          amt_sh, slow_sh;
    logic                arg_second;
    logic [IDX_W-1:0]    idx;
    logic [TO_W-1:0]     tmo_cnt;
    logic [DATA_BIT-1:0] pat_sh, pat_next;
    logic                timeout, finish, commit, err_d;

    assign cmd_in  = decode_cmd(data_i);
    // A tick in the terminal cycle keeps the frame alive.
    assign timeout = (state != ST_IDLE) && !rx_done_tick_i &&
                     (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        finish  = 1'b0;
        commit  = 1'b0;
        err_d   = 1'b0;
        if (rx_done_tick_i) begin
            case (state)
                ST_IDLE: begin
                    case (cmd_in)
                        CM_NONE:                     err_d   = 1'b1;
                        CM_DATA, CM_CTRL, CM_REPEAT: state_d = ST_CH;
                        CM_FREQ:                     state_d = ST_AMT;
                        default:                     state_d = ST_ARG;
                    endcase
                end
                ST_CH:   state_d = (cmd == CM_DATA) ? ST_AMT : ST_ARG;
                ST_AMT:  state_d = ST_PAY;
                ST_PAY:  finish  = (idx == IDX_W'(PAY_BYTES - 1));
                ST_ARG:  finish  = (cmd != CM_PERIOD) || arg_second;
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
        if (finish) begin
            state_d = ST_IDLE;
            if (has_channel(cmd) && !ch_ok) err_d  = 1'b1;
            else                             commit = 1'b1;
        end
    end

    always_comb begin
        pat_next = pat_sh;
        for (int k = 0; k < PAY_BYTES; k++) begin
            if (idx == IDX_W'(k)) pat_next[8*k +: 8] = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cmd           <= CM_NONE;
            ch            <= '0;
            ch_ok         <= 1'b0;
            amt_sh        <= '0;
            slow_sh       <= '0;
            arg_second    <= 1'b0;
            idx           <= '0;
            tmo_cnt       <= '0;
            pat_sh        <= '0;
            data_we_o     <= 1'b0;
            ctrl_we_o     <= 1'b0;
            freq_we_o     <= 1'b0;
            period_we_o   <= 1'b0;
            repeat_we_o   <= 1'b0;
            global_we_o   <= 1'b0;
            channel_o     <= '0;
            amount_o      <= '0;
            pattern_o     <= '0;
            idle_o        <= 1'b0;
            mode_o        <= '0;
            en_o          <= 1'b0;
            slow_period_o <= '0;
            fast_period_o <= '0;
            repeat_o      <= '0;
            stop_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            err_o       <= err_d;
            data_we_o   <= 1'b0;
            ctrl_we_o   <= 1'b0;
            freq_we_o   <= 1'b0;
            period_we_o <= 1'b0;
            repeat_we_o <= 1'b0;
            global_we_o <= 1'b0;

            if (rx_done_tick_i || state == ST_IDLE || timeout) tmo_cnt <= '0;
            else                                               tmo_cnt <= tmo_cnt + TO_W'(1);

            if (rx_done_tick_i) begin
                case (state)
                    ST_IDLE: begin
                        cmd        <= cmd_in;
                        arg_second <= 1'b0;
                    end
                    ST_CH: begin
                        ch    <= data_i[CH_W-1:0];
                        ch_ok <= ({1'b0, data_i} < 9'(OUTPUT_NUM));
                    end
                    ST_AMT: begin
                        amt_sh <= data_i;
                        idx    <= '0;
                    end
                    ST_PAY: begin
                        pat_sh <= pat_next;
                        idx    <= idx + IDX_W'(1);
                    end
                    ST_ARG: begin
                        slow_sh    <= data_i;
                        arg_second <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (commit) begin
                case (cmd)
                    CM_DATA: begin
                        data_we_o <= 1'b1;
                        channel_o <= ch;
                        amount_o  <= amt_sh;
                        pattern_o <= pat_next;
                    end
                    CM_CTRL: begin
                        ctrl_we_o <= 1'b1;
                        channel_o <= ch;
                        idle_o    <= data_i[3];
                        mode_o    <= data_i[2:1];
                        en_o      <= data_i[0];
                    end
                    CM_FREQ: begin
                        freq_we_o <= 1'b1;
                        amount_o  <= amt_sh;
                        pattern_o <= pat_next;
                    end
                    CM_PERIOD: begin
                        period_we_o   <= 1'b1;
                        slow_period_o <= slow_sh;
                        fast_period_o <= data_i;
                    end
                    CM_REPEAT: begin
                        repeat_we_o <= 1'b1;
                        channel_o   <= ch;
                        repeat_o    <= data_i;
                    end
                    CM_GLOBAL: begin
                        global_we_o <= 1'b1;
                        stop_o      <= data_i[0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: randomized and directed frames checked against a frame-level reference model.
// Rev 1.0
`default_nettype none

module tb_uart_cmd_decoder;
    import uart_cmd_decoder_pkg::*;

    localparam int OUTPUT_NUM = 16;
    localparam int DATA_BIT   = 32;
    localparam int TMO        = 64;
    localparam int PAY_BYTES  = DATA_BIT / 8;
    localparam int CH_W       = 4;

    localparam logic [6:0] EV_DATA   = 7'b1000000;
    localparam logic [6:0] EV_CTRL   = 7'b0100000;
    localparam logic [6:0] EV_FREQ   = 7'b0010000;
    localparam logic [6:0] EV_PERIOD = 7'b0001000;
    localparam logic [6:0] EV_REPEAT = 7'b0000100;
    localparam logic [6:0] EV_GLOBAL = 7'b0000010;
    localparam logic [6:0] EV_ERR    = 7'b0000001;

    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic data_we, ctrl_we, freq_we, period_we, repeat_we, global_we, err;
    logic [CH_W-1:0] channel;
    logic [7:0] amount, slow, fast, rep;
    logic [DATA_BIT-1:0] pattern;
    logic idle, en, stop;
    logic [1:0] mode;

    uart_cmd_decoder #(.OUTPUT_NUM(OUTPUT_NUM), .DATA_BIT(DATA_BIT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .data_i(din), .rx_done_tick_i(tick),
        .data_we_o(data_we), .ctrl_we_o(ctrl_we), .freq_we_o(freq_we),
        .period_we_o(period_we), .repeat_we_o(repeat_we), .global_we_o(global_we),
        .channel_o(channel), .amount_o(amount), .pattern_o(pattern),
        .idle_o(idle), .mode_o(mode), .en_o(en),
        .slow_period_o(slow), .fast_period_o(fast), .repeat_o(rep),
        .stop_o(stop), .err_o(err)
    );

    always #5 clk = ~clk;

    // Expected output fields, updated a whole frame at a time.
    logic [CH_W-1:0] e_channel;
    logic [7:0] e_amount, e_slow, e_fast, e_repeat;
    logic [DATA_BIT-1:0] e_pattern;
    logic e_idle, e_en, e_stop;
    logic [1:0] e_mode;

    logic [6:0]  ev_vec, zero_ev;
    logic [72:0] fld_vec, exp_vec, zero_fld;
    assign ev_vec   = {data_we, ctrl_we, freq_we, period_we, repeat_we, global_we, err};
    assign fld_vec  = {channel, amount, pattern, idle, mode, en, slow, fast, rep, stop};
    assign exp_vec  = {e_channel, e_amount, e_pattern, e_idle, e_mode, e_en, e_slow, e_fast, e_repeat, e_stop};
    assign zero_ev  = '0;
    assign zero_fld = '0;

    int checks = 0, errors = 0;
    int n_strobe = 0, n_err = 0, n_multi = 0;
    logic [7:0] frm[$];

    always @(negedge clk) begin
        n_strobe <= n_strobe + $countones(ev_vec[6:1]);
        n_err    <= n_err + (ev_vec[0] ? 1 : 0);
        if ($countones(ev_vec) > 1) n_multi <= n_multi + 1;
    end

    task automatic model_reset();
        e_channel = '0; e_amount = '0; e_pattern = '0; e_idle = 1'b0; e_mode = '0;
        e_en = 1'b0; e_slow = '0; e_fast = '0; e_repeat = '0; e_stop = 1'b0;
    endtask

    task automatic model_frame(output logic [6:0] ev);
        logic [7:0] b1, b2;
        ev = EV_ERR;
        b1 = (frm.size() > 1) ? frm[1] : 8'h00;
        b2 = (frm.size() > 2) ? frm[2] : 8'h00;
        case (frm[0])
            CMD_DATA: if (int'(b1) < OUTPUT_NUM) begin
                ev = EV_DATA; e_channel = CH_W'(b1); e_amount = b2;
                for (int k = 0; k < PAY_BYTES; k++) e_pattern[8*k +: 8] = frm[3+k];
            end
            CMD_CTRL: if (int'(b1) < OUTPUT_NUM) begin
                ev = EV_CTRL; e_channel = CH_W'(b1);
                e_idle = b2[3]; e_mode = b2[2:1]; e_en = b2[0];
            end
            CMD_FREQ: begin
                ev = EV_FREQ; e_amount = b1;
                for (int k = 0; k < PAY_BYTES; k++) e_pattern[8*k +: 8] = frm[2+k];
            end
            CMD_PERIOD: begin
                ev = EV_PERIOD; e_slow = b1; e_fast = b2;
            end
            CMD_REPEAT: if (int'(b1) < OUTPUT_NUM) begin
                ev = EV_REPEAT; e_channel = CH_W'(b1); e_repeat = b2;
            end
            CMD_GLOBAL: begin
                ev = EV_GLOBAL; e_stop = b1[0];
            end
            default: ;
        endcase
    endtask

    // Sends frm; returns at #1 after the edge sampling the last tick (the strobe cycle).
    task automatic send_frame(input int gmin, input int gmax, output logic [6:0] ev);
        model_frame(ev);
        for (int i = 0; i < frm.size(); i++) begin
            din = frm[i]; tick = 1'b1;
            @(posedge clk); #1; tick = 1'b0;
            if (i < frm.size() - 1) begin
                int g;
                g = $urandom_range(gmax, gmin);
                repeat (g) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic settle();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic gen_frame();
        int kind;
        logic [7:0] ch, b;
        kind = $urandom_range(6, 0);
        ch   = 8'($urandom_range(19, 0));
        frm.delete();
        case (kind)
            0: begin
                frm.push_back(CMD_DATA); frm.push_back(ch); frm.push_back(8'($urandom));
                for (int k = 0; k < PAY_BYTES; k++) frm.push_back(8'($urandom));
            end
            1: begin frm.push_back(CMD_CTRL); frm.push_back(ch); frm.push_back(8'($urandom)); end
            2: begin
                frm.push_back(CMD_FREQ); frm.push_back(8'($urandom));
                for (int k = 0; k < PAY_BYTES; k++) frm.push_back(8'($urandom));
            end
            3: begin frm.push_back(CMD_PERIOD); frm.push_back(8'($urandom)); frm.push_back(8'($urandom)); end
            4: begin frm.push_back(CMD_REPEAT); frm.push_back(ch); frm.push_back(8'($urandom)); end
            5: begin frm.push_back(CMD_GLOBAL); frm.push_back(8'($urandom)); end
            default: begin
                b = 8'($urandom);
                while (b inside {CMD_DATA, CMD_CTRL, CMD_FREQ, CMD_PERIOD, CMD_REPEAT, CMD_GLOBAL})
                    b = 8'($urandom);
                frm.push_back(b);
            end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b1; din = CMD_GLOBAL;
        repeat (3) @(posedge clk);
        #1; tick = 1'b0;
        model_reset();
        checks++; if (fld_vec !== zero_fld) begin errors++; $display("FAIL reset_fields: got %h expected %h", fld_vec, zero_fld); end
        checks++; if (ev_vec !== zero_ev) begin errors++; $display("FAIL reset_strobes: got %b expected %b", ev_vec, zero_ev); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ev_vec !== zero_ev) begin errors++; $display("FAIL post_reset_strobes: got %b expected %b", ev_vec, zero_ev); end
    endtask

    task automatic test_data_frame();
        logic [6:0] ev;
        frm = '{CMD_DATA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(0, 2, ev);
        checks++; if (ev_vec !== EV_DATA) begin errors++; $display("FAIL data_strobe: got %b expected %b", ev_vec, EV_DATA); end
        checks++; if (channel !== 4'd3) begin errors++; $display("FAIL data_channel: got %0d expected 3", channel); end
        checks++; if (amount !== 8'd2) begin errors++; $display("FAIL data_amount: got %0d expected 2", amount); end
        checks++; if (pattern !== 32'h4433_2211) begin errors++; $display("FAIL data_pattern: got %h expected 44332211", pattern); end
        @(posedge clk); #1;
        checks++; if (ev_vec !== zero_ev) begin errors++; $display("FAIL data_one_cycle: got %b expected %b", ev_vec, zero_ev); end
        checks++; if (fld_vec !== exp_vec) begin errors++; $display("FAIL data_hold: got %h expected %h", fld_vec, exp_vec); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ev;
        int base;
        settle();
        base = n_strobe + n_err;
        frm = '{CMD_CTRL, 8'd14, 8'h0D};
        send_frame(0, 1, ev);
        checks++; if (ev_vec !== EV_CTRL) begin errors++; $display("FAIL ctrl_strobe: got %b expected %b", ev_vec, EV_CTRL); end
        checks++; if ({channel, idle, mode, en} !== {4'd14, 1'b1, 2'b10, 1'b1}) begin
            errors++; $display("FAIL ctrl_fields: got %h expected %h", {channel, idle, mode, en}, {4'd14, 1'b1, 2'b10, 1'b1});
        end
        frm = '{CMD_PERIOD, 8'h14, 8'h05};
        send_frame(0, 0, ev);
        checks++; if (ev_vec !== EV_PERIOD) begin errors++; $display("FAIL period_strobe: got %b expected %b", ev_vec, EV_PERIOD); end
        checks++; if ({slow, fast} !== 16'h1405) begin errors++; $display("FAIL period_fields: got %h expected 1405", {slow, fast}); end
        checks++; if (fld_vec !== exp_vec) begin errors++; $display("FAIL b2b_fields: got %h expected %h", fld_vec, exp_vec); end
        settle();
        checks++; if (n_strobe + n_err - base !== 2) begin errors++; $display("FAIL b2b_event_count: got %0d expected 2", n_strobe + n_err - base); end
    endtask

    task automatic test_bad_channel();
        logic [6:0] ev;
        logic [7:0] prev_rep;
        prev_rep = rep;
        frm = '{CMD_REPEAT, 8'd16, 8'h07};
        send_frame(0, 2, ev);
        checks++; if (ev_vec !== EV_ERR) begin errors++; $display("FAIL badch_err: got %b expected %b", ev_vec, EV_ERR); end
        checks++; if (fld_vec !== exp_vec) begin errors++; $display("FAIL badch_fields: got %h expected %h", fld_vec, exp_vec); end
        checks++; if (rep !== prev_rep) begin errors++; $display("FAIL badch_repeat: got %h expected %h", rep, prev_rep); end
        frm = '{CMD_GLOBAL, 8'h01};
        send_frame(0, 0, ev);
        checks++; if ({ev_vec, stop} !== {EV_GLOBAL, 1'b1}) begin errors++; $display("FAIL global: got %b expected %b", {ev_vec, stop}, {EV_GLOBAL, 1'b1}); end
    endtask

    task automatic test_unknown_freq();
        logic [6:0] ev;
        frm = '{8'hFF};
        send_frame(0, 0, ev);
        checks++; if (ev_vec !== EV_ERR) begin errors++; $display("FAIL unknown_err: got %b expected %b", ev_vec, EV_ERR); end
        frm = '{CMD_FREQ, 8'd4, 8'h55, 8'h55, 8'h55, 8'h55};
        send_frame(0, 3, ev);
        checks++; if (ev_vec !== EV_FREQ) begin errors++; $display("FAIL freq_strobe: got %b expected %b", ev_vec, EV_FREQ); end
        checks++; if ({amount, pattern} !== {8'd4, 32'h5555_5555}) begin
            errors++; $display("FAIL freq_fields: got %h expected %h", {amount, pattern}, {8'd4, 32'h5555_5555});
        end
        checks++; if (fld_vec !== exp_vec) begin errors++; $display("FAIL freq_all: got %h expected %h", fld_vec, exp_vec); end
    endtask

    task automatic test_timeout();
        logic [6:0] ev;
        int bs, be;
        settle();
        bs = n_strobe; be = n_err;
        frm = '{CMD_DATA, 8'd5, 8'd1, 8'hAA, 8'hBB};
        for (int i = 0; i < frm.size(); i++) begin
            din = frm[i]; tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
        end
        repeat (2 * TMO + 4) begin @(posedge clk); #1; end
        checks++; if (n_err - be !== 1) begin errors++; $display("FAIL timeout_err: got %0d expected 1", n_err - be); end
        checks++; if (n_strobe - bs !== 0) begin errors++; $display("FAIL timeout_strobe: got %0d expected 0", n_strobe - bs); end
        checks++; if (fld_vec !== exp_vec) begin errors++; $display("FAIL timeout_fields: got %h expected %h", fld_vec, exp_vec); end
        frm = '{CMD_DATA, 8'd9, 8'h77, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(TMO - 2, TMO - 2, ev);
        checks++; if (ev_vec !== EV_DATA) begin errors++; $display("FAIL slow_frame_strobe: got %b expected %b", ev_vec, EV_DATA); end
        checks++; if (fld_vec !== exp_vec) begin errors++; $display("FAIL slow_frame_fields: got %h expected %h", fld_vec, exp_vec); end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] ev;
        int be;
        settle();
        be = n_err;
        frm = '{CMD_CTRL, 8'd2};
        for (int i = 0; i < frm.size(); i++) begin
            din = frm[i]; tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
        end
        rst_n = 1'b0; tick = 1'b1; din = CMD_GLOBAL;
        repeat (2) begin @(posedge clk); #1; end
        tick = 1'b0;
        checks++; if (fld_vec !== zero_fld) begin errors++; $display("FAIL midreset_fields: got %h expected %h", fld_vec, zero_fld); end
        checks++; if (ev_vec !== zero_ev) begin errors++; $display("FAIL midreset_strobes: got %b expected %b", ev_vec, zero_ev); end
        rst_n = 1'b1;
        model_reset();
        settle();
        checks++; if (n_err !== be) begin errors++; $display("FAIL midreset_no_err: got %0d expected %0d", n_err, be); end
        frm = '{CMD_CTRL, 8'd2, 8'h03};
        send_frame(0, 1, ev);
        checks++; if (ev_vec !== EV_CTRL) begin errors++; $display("FAIL after_reset_strobe: got %b expected %b", ev_vec, EV_CTRL); end
        checks++; if (fld_vec !== exp_vec) begin errors++; $display("FAIL after_reset_fields: got %h expected %h", fld_vec, exp_vec); end
    endtask

    task automatic test_random();
        logic [6:0] ev;
        int base, n_frames;
        settle();
        base = n_strobe + n_err;
        n_frames = 60;
        for (int f = 0; f < n_frames; f++) begin
            gen_frame();
            send_frame(0, 3, ev);
            checks++; if (ev_vec !== ev) begin errors++; $display("FAIL rand%0d_strobe: got %b expected %b", f, ev_vec, ev); end
            checks++; if (fld_vec !== exp_vec) begin errors++; $display("FAIL rand%0d_fields: got %h expected %h", f, fld_vec, exp_vec); end
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end
        settle();
        checks++; if (n_strobe + n_err - base !== n_frames) begin
            errors++; $display("FAIL rand_event_count: got %0d expected %0d", n_strobe + n_err - base, n_frames);
        end
        checks++; if (n_multi !== 0) begin errors++; $display("FAIL multi_pulse_cycles: got %0d expected 0", n_multi); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_data_frame();
        test_back_to_back();
        test_bad_channel();
        test_unknown_freq();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-stream command parser between the UART receiver and the diff_freq_serial_out channel bank. It consumes `rx_data`/`rx_done_tick` bytes and reassembles the six host command frames (DATA, CTRL, FREQ, PERIOD, REPEAT, GLOBAL). For each complete, valid frame it emits a one-cycle write strobe with registered payload fields that the channel bank loads. Malformed, out-of-range and stalled frames are discarded and flagged.

## Interface
- `OUTPUT_NUM`, 16: number of serial-out channels; `CH_W = $clog2(OUTPUT_NUM)`.
- `DATA_BIT`, 32: pattern width, multiple of 8; `PAY_BYTES = DATA_BIT/8`.
- `TIMEOUT_CYCLES`, 100000: max idle clocks between bytes inside a frame.
- `clk_i` in 1: system clock; the block uses this single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `data_i` in 8: received byte, valid when `rx_done_tick_i`=1.
- `rx_done_tick_i` in 1: one-cycle byte-valid pulse from the UART.
- `data_we_o`, `ctrl_we_o`, `freq_we_o`, `period_we_o`, `repeat_we_o`, `global_we_o` out 1 each: one-cycle commit strobes.
- `channel_o` out CH_W: target channel (DATA/CTRL/REPEAT).
- `amount_o` out 8: amount byte (DATA/FREQ).
- `pattern_o` out DATA_BIT: assembled pattern (DATA/FREQ).
- `idle_o` out 1, `mode_o` out 2, `en_o` out 1: CTRL fields.
- `slow_period_o`, `fast_period_o` out 8: PERIOD args.
- `repeat_o` out 8: REPEAT count.
- `stop_o` out 1: GLOBAL stop bit.
- `err_o` out 1: one-cycle pulse on a discarded frame.

## Operation
- Frame formats, byte order as received:
  - DATA: CMD_DATA, channel, amount, PAY_BYTES pattern bytes.
  - CTRL: CMD_CTRL, channel, ctrl.
  - FREQ: CMD_FREQ, amount, PAY_BYTES pattern bytes.
  - PERIOD: CMD_PERIOD, slow, fast.
  - REPEAT: CMD_REPEAT, channel, times.
  - GLOBAL: CMD_GLOBAL, arg.
- Pattern bytes arrive LSB first: byte k is written to `pattern[8k+7:8k]`. Bits not yet written keep their previous value until commit.
- CTRL byte mapping: idle=bit3, mode=bits[2:1], en=bit0. Bits[7:4] are ignored.
- GLOBAL: stop=arg bit0. Bits[7:1] are ignored.
- FSM states:
  - IDLE: a tick with a known CMD latches the command and goes to CH (DATA/CTRL/REPEAT), AMT (FREQ), or ARG (PERIOD/GLOBAL). An unknown byte pulses `err_o` and stays in IDLE.
  - CH: the tick latches the channel. DATA→AMT; CTRL/REPEAT→ARG.
  - AMT: the tick latches the amount; go to PAY with byte index 0.
  - PAY: each tick stores one byte and increments the index. The byte at index PAY_BYTES-1 triggers commit.
  - ARG: one byte for CTRL/REPEAT/GLOBAL, then commit. For PERIOD, the first byte is slow and the second is fast, then commit.
- Commit: assert the strobe for the latched command, update that command's output fields, and return to IDLE.
- Channel byte ≥ OUTPUT_NUM: the frame is still consumed to its full length. At the end there is no strobe and no field update; `err_o` pulses instead.
- Timeout: the counter clears on every tick and counts only outside IDLE. When it reaches TIMEOUT_CYCLES, go to IDLE, pulse `err_o`, and produce no strobe. The partial frame is dropped.
- Output fields hold their last committed value between frames. Fields of non-committed commands are not disturbed.

## Timing
- Reset values: all outputs 0; FSM in IDLE; byte index, timeout counter and internal shadow registers 0.
- Commit latency: the strobe and updated fields appear exactly 1 cycle after the `rx_done_tick_i` of the frame's last byte.
  - Fields are valid in the strobe cycle and stay stable afterwards.
- At most one strobe or `err_o` is high in any cycle.
- Back-to-back frames: the FSM is in IDLE during the strobe cycle, so a tick in that cycle is accepted as a new CMD byte.
- `rx_done_tick_i` is ignored while `rst_ni`=0. Reset mid-frame discards the frame with no strobe and no error.
- Timeout precedence: if a tick and the timeout terminal count coincide, the tick wins and the counter clears.

## Structure
- Command codes CMD_DATA, CMD_CTRL, CMD_FREQ, CMD_PERIOD, CMD_REPEAT, CMD_GLOBAL come from the shared `user_cmd.vh`.
- Mode encodings ONE_SHOT=2'b00, CONTINUE=2'b01, REPEAT=2'b10 also come from `user_cmd.vh`.
- No sub-module. The byte-index counter and timeout counter are local.

## Test plan
- DATA frame: CMD_DATA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44 → 1 cycle after the last tick, `data_we_o`=1, `channel_o`=3, `amount_o`=2, `pattern_o`=32'h4433_2211.
- CTRL then PERIOD back to back: CTRL ch 14 ctrl 8'h0D, then PERIOD 8'h14, 8'h05 →
  - CTRL commit: `idle_o`=1, `mode_o`=2'b10, `en_o`=1.
  - PERIOD commit: `slow_period_o`=8'h14, `fast_period_o`=8'h05.
  - Exactly two strobes total.
- REPEAT to channel 16, then GLOBAL 8'h01 →
  - REPEAT: consumed with `err_o` pulse, no `repeat_we_o`, `repeat_o` unchanged.
  - GLOBAL: `global_we_o`=1 with `stop_o`=1.
- Unknown byte 8'hFF, then FREQ 4, 55,55,55,55 →
  - 8'hFF: one `err_o` pulse.
  - FREQ: `freq_we_o`=1, `amount_o`=4, `pattern_o`=32'h5555_5555.
- Stall and reset:
  - DATA frame stopped after 2 pattern bytes for TIMEOUT_CYCLES → `err_o` pulse, no strobe; a following full frame decodes correctly.
  - `rst_ni`=0 mid-frame → all outputs 0 and no error pulse.
